// File: rtl/tmds_symbol_aligner.sv
// TMDS receive-side symbol aligner and decoder for one data channel.
// Finds the 10-bit symbol boundary from control-token runs in blanking, then decodes each symbol.
module tmds_symbol_aligner #(
  parameter int SEARCH_WINDOW = 4096,
  parameter int TOKEN_RUN     = 16,
  parameter int LOCK_TIMEOUT  = 8192
) (
  input  logic       pixelClock,
  input  logic       resetN,
  input  logic [9:0] rawSymbol,
  output logic [9:0] alignedSymbol,
  output logic [7:0] videoData,
  output logic [1:0] controlBits,
  output logic       isControl,
  output logic       locked,
  output logic [3:0] offset
);

  // Streaming datapath without valid/ready: one word is accepted and one
  // decoded symbol is produced on every pixelClock edge.
  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } alignState_t;

  localparam logic [15:0] WINDOW_LAST = 16'(SEARCH_WINDOW - 1);
  localparam logic [15:0] RUN_TARGET  = 16'(TOKEN_RUN);
  localparam logic [15:0] GAP_LIMIT   = 16'(LOCK_TIMEOUT);

  alignState_t state;
  logic [9:0]  r0;
  logic [9:0]  r1;
  logic [9:0]  aligned;
  logic [9:0]  alignedNext;
  logic [15:0] runCount;
  logic [15:0] timer;
  logic [15:0] gap;
  logic [15:0] runNext;
  logic [15:0] gapNext;
  logic        stale;
  logic [7:0]  tByte;
  logic [7:0]  dByte;
  logic        tokenHit;
  logic [1:0]  tokenCode;

  function automatic logic [15:0] satInc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // r1 holds the older word, so its bits come first in the 20-bit window.
  assign alignedNext = 10'({r0, r1} >> offset);

  always_comb begin
    tByte = aligned[9] ? ~aligned[7:0] : aligned[7:0];
    dByte = '0;
    dByte[0] = tByte[0];
    for (int i = 1; i < 8; i++) begin
      dByte[i] = aligned[8] ? (tByte[i] ^ tByte[i-1]) : ~(tByte[i] ^ tByte[i-1]);
    end
  end

  always_comb begin
    tokenHit  = 1'b1;
    tokenCode = 2'b00;
    case (aligned)
      10'b1101010100: tokenCode = 2'b00;
      10'b0010101011: tokenCode = 2'b01;
      10'b0101010100: tokenCode = 2'b10;
      10'b1010101011: tokenCode = 2'b11;
      default:        tokenHit  = 1'b0;
    endcase
  end

  // The symbol right after an offset change was sliced at the old offset.
  assign runNext = (tokenHit && !stale) ? satInc(runCount) : '0;
  assign gapNext = satInc(gap);

  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      state         <= SEARCH;
      r0            <= '0;
      r1            <= '0;
      aligned       <= '0;
      alignedSymbol <= '0;
      videoData     <= '0;
      controlBits   <= '0;
      isControl     <= 1'b0;
      locked        <= 1'b0;
      offset        <= '0;
      runCount      <= '0;
      timer         <= '0;
      gap           <= '0;
      stale         <= 1'b0;
    end else begin
      r0            <= rawSymbol;
      r1            <= r0;
      aligned       <= alignedNext;
      alignedSymbol <= aligned;
      videoData     <= dByte;
      isControl     <= tokenHit;
      if (tokenHit) controlBits <= tokenCode;
      stale <= 1'b0;

      case (state)
        SEARCH: begin
          if (runNext >= RUN_TARGET) begin
            state    <= LOCKED;
            locked   <= 1'b1;
            runCount <= '0;
            timer    <= '0;
            gap      <= '0;
          end else if (timer >= WINDOW_LAST) begin
            offset   <= (offset == 4'd9) ? 4'd0 : offset + 4'd1;
            runCount <= '0;
            timer    <= '0;
            stale    <= 1'b1;
          end else begin
            runCount <= runNext;
            timer    <= satInc(timer);
          end
        end
        LOCKED: begin
          if (tokenHit) begin
            gap <= '0;
          end else if (gapNext >= GAP_LIMIT) begin
            state    <= SEARCH;
            locked   <= 1'b0;
            gap      <= '0;
            runCount <= '0;
            timer    <= '0;
          end else begin
            gap <= gapNext;
          end
        end
        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tmds_symbol_aligner.sv
// Self-checking bench for tmds_symbol_aligner: scoreboarded decode path plus
// lock, offset-search, timeout and reset scenarios.
module tb_tmds_symbol_aligner;

  localparam int SW = 64;
  localparam int TR = 16;
  localparam int LT = 100;

  localparam logic [9:0] TOK00 = 10'b1101010100;
  localparam logic [9:0] TOK01 = 10'b0010101011;
  localparam logic [9:0] TOK10 = 10'b0101010100;
  localparam logic [9:0] TOK11 = 10'b1010101011;
  localparam logic [9:0] VID00 = 10'b0100000000;
  localparam logic [9:0] VIDFF = 10'b1000000000;

  logic       pixelClock;
  logic       resetN;
  logic [9:0] rawSymbol;
  logic [9:0] alignedSymbol;
  logic [7:0] videoData;
  logic [1:0] controlBits;
  logic       isControl;
  logic       locked;
  logic [3:0] offset;

  int          nCompared   = 0;
  int          nMismatched = 0;
  logic [20:0] expQ[$];
  logic        sbOn = 1'b0;
  logic [1:0]  sbCb = 2'b00;

  tmds_symbol_aligner #(
    .SEARCH_WINDOW(SW),
    .TOKEN_RUN(TR),
    .LOCK_TIMEOUT(LT)
  ) dut (
    .pixelClock(pixelClock),
    .resetN(resetN),
    .rawSymbol(rawSymbol),
    .alignedSymbol(alignedSymbol),
    .videoData(videoData),
    .controlBits(controlBits),
    .isControl(isControl),
    .locked(locked),
    .offset(offset)
  );

  // Clock and reset
  initial begin
    pixelClock = 1'b0;
    forever #5 pixelClock = ~pixelClock;
  end

  task automatic applyReset();
    @(negedge pixelClock);
    resetN = 1'b0;
    sbOn = 1'b0;
    expQ.delete();
    for (int i = 0; i < 3; i++) begin
      rawSymbol = 10'($urandom_range(0, 1023));
      @(posedge pixelClock);
    end
    @(negedge pixelClock);
    resetN = 1'b1;
  endtask

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] expVal);
    nCompared++;
    if (got !== expVal) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, expVal, $time);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, ".alignedSymbol"}, 32'(alignedSymbol), 0);
    checkVal({tag, ".videoData"}, 32'(videoData), 0);
    checkVal({tag, ".controlBits"}, 32'(controlBits), 0);
    checkVal({tag, ".isControl"}, 32'(isControl), 0);
    checkVal({tag, ".locked"}, 32'(locked), 0);
    checkVal({tag, ".offset"}, 32'(offset), 0);
  endtask

  // Reference decode
  function automatic logic isToken(input logic [9:0] q);
    return (q == TOK00) || (q == TOK01) || (q == TOK10) || (q == TOK11);
  endfunction

  function automatic logic [1:0] tokenValue(input logic [9:0] q);
    logic [1:0] c;
    case (q)
      TOK01:   c = 2'b01;
      TOK10:   c = 2'b10;
      TOK11:   c = 2'b11;
      default: c = 2'b00;
    endcase
    return c;
  endfunction

  function automatic logic [7:0] decodeVideo(input logic [9:0] q);
    logic [7:0] t;
    logic [7:0] d;
    t = q[9] ? ~q[7:0] : q[7:0];
    d = '0;
    d[0] = t[0];
    for (int i = 1; i < 8; i++) d[i] = q[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
    return d;
  endfunction

  function automatic logic [9:0] randomVideo();
    logic [9:0] w;
    do w = 10'($urandom_range(0, 1023)); while (isToken(w));
    return w;
  endfunction

  // Serial stream whose symbols start 7 bits into each word:
  // repeating 200 x TOK10 then 100 x VID00.
  function automatic logic [9:0] shiftedWord(input int n);
    logic [9:0] w;
    logic [9:0] sym;
    int idx;
    int s;
    w = '0;
    for (int b = 0; b < 10; b++) begin
      idx = 10 * n + b;
      if (idx >= 7) begin
        s = (idx - 7) / 10;
        sym = ((s % 300) < 200) ? TOK10 : VID00;
        w[b] = sym[(idx - 7) % 10];
      end
    end
    return w;
  endfunction

  // Driver plus scoreboard: expectation pushed on drive, popped 3 edges later
  task automatic driveWord(input logic [9:0] w);
    logic [20:0] expEntry;
    rawSymbol = w;
    if (sbOn) begin
      if (isToken(w)) sbCb = tokenValue(w);
      expQ.push_back({w, decodeVideo(w), isToken(w), sbCb});
    end
    @(posedge pixelClock);
    #1;
    if (sbOn && expQ.size() >= 4) begin
      expEntry = expQ.pop_front();
      checkVal("sb.alignedSymbol", 32'(alignedSymbol), 32'(expEntry[20:11]));
      checkVal("sb.videoData", 32'(videoData), 32'(expEntry[10:3]));
      checkVal("sb.isControl", 32'(isControl), 32'(expEntry[2]));
      checkVal("sb.controlBits", 32'(controlBits), 32'(expEntry[1:0]));
    end
  endtask

  initial begin
    resetN = 1'b0;
    rawSymbol = '0;

    // Reset held with random input, then random non-token data: offset wraps 9 -> 0
    for (int i = 0; i < 4; i++) begin
      rawSymbol = 10'($urandom_range(0, 1023));
      @(posedge pixelClock);
      #1;
    end
    checkAllZero("resetHold");
    @(negedge pixelClock);
    resetN = 1'b1;
    for (int n = 0; n < 640; n++) begin
      driveWord(randomVideo());
      if (n == 100) checkVal("noTokens.locked", 32'(locked), 0);
      if (n == 638) checkVal("wrap.offsetAt9", 32'(offset), 9);
      if (n == 639) begin
        checkVal("wrap.offsetTo0", 32'(offset), 0);
        checkVal("wrap.locked", 32'(locked), 0);
      end
    end

    // Aligned lock followed by scoreboarded decode traffic
    applyReset();
    sbCb = 2'b00;
    sbOn = 1'b1;
    for (int n = 0; n < 20; n++) begin
      driveWord(TOK00);
      if (n == 2) checkVal("lock0.isControlEdge2", 32'(isControl), 0);
      if (n == 3) checkVal("lock0.isControlEdge3", 32'(isControl), 1);
      if (n == 17) checkVal("lock0.lockedEdge17", 32'(locked), 0);
      if (n == 18) begin
        checkVal("lock0.lockedEdge18", 32'(locked), 1);
        checkVal("lock0.offset", 32'(offset), 0);
        checkVal("lock0.controlBits", 32'(controlBits), 0);
      end
    end
    driveWord(VID00);
    driveWord(VIDFF);
    driveWord(TOK11);
    driveWord(TOK00);
    checkVal("dec.vid00.videoData", 32'(videoData), 32'h00);
    checkVal("dec.vid00.isControl", 32'(isControl), 0);
    driveWord(randomVideo());
    checkVal("dec.vidFF.videoData", 32'(videoData), 32'hFF);
    driveWord(randomVideo());
    checkVal("dec.tok11.isControl", 32'(isControl), 1);
    checkVal("dec.tok11.controlBits", 32'(controlBits), 3);
    for (int i = 0; i < 5; i++) driveWord(randomVideo());
    driveWord(TOK01);
    for (int i = 0; i < 3; i++) driveWord(TOK00);

    // Loss of lock after LOCK_TIMEOUT video symbols, then relock at same offset
    for (int j = 1; j <= 103; j++) begin
      driveWord(randomVideo());
      if (j == 102) checkVal("timeout.lockedAt99", 32'(locked), 1);
      if (j == 103) begin
        checkVal("timeout.lockedAt100", 32'(locked), 0);
        checkVal("timeout.offsetKept", 32'(offset), 0);
      end
    end
    for (int t = 1; t <= 21; t++) begin
      driveWord(TOK10);
      if (t == 18) checkVal("relock.before", 32'(locked), 0);
      if (t == 19) begin
        checkVal("relock.locked", 32'(locked), 1);
        checkVal("relock.offset", 32'(offset), 0);
      end
    end

    // Token arriving exactly when the gap would reach the timeout keeps lock
    for (int v = 1; v <= 99; v++) driveWord(randomVideo());
    driveWord(TOK10);
    driveWord(TOK10);
    driveWord(TOK10);
    checkVal("gapTie.lockedAtTie", 32'(locked), 1);
    driveWord(TOK10);
    checkVal("gapTie.lockedAfter", 32'(locked), 1);
    sbOn = 1'b0;

    // Run completes on the same edge the search timer expires: lock wins
    applyReset();
    for (int n = 0; n <= 70; n++) begin
      driveWord((n >= 45) ? TOK00 : VID00);
      if (n == 62) checkVal("tie.lockedBefore", 32'(locked), 0);
      if (n == 63) begin
        checkVal("tie.locked", 32'(locked), 1);
        checkVal("tie.offset", 32'(offset), 0);
      end
      if (n == 70) checkVal("tie.offsetHeld", 32'(offset), 0);
    end

    // Stream shifted by 7 bits: offset steps every SW cycles and locks at 7
    applyReset();
    for (int n = 0; n <= 470; n++) begin
      driveWord(shiftedWord(n));
      if (n < 448 && ((n + 2) % SW) == 0)
        checkVal("shift.offsetBefore", 32'(offset), 32'((n + 2) / SW - 1));
      if (n < 448 && ((n + 1) % SW) == 0)
        checkVal("shift.offsetStep", 32'(offset), 32'((n + 1) / SW));
      if (n == 463) checkVal("shift.lockedBefore", 32'(locked), 0);
      if (n == 464) begin
        checkVal("shift.locked", 32'(locked), 1);
        checkVal("shift.offset", 32'(offset), 7);
        checkVal("shift.controlBits", 32'(controlBits), 2);
        checkVal("shift.isControl", 32'(isControl), 1);
      end
      if (n == 470) checkVal("shift.offsetFrozen", 32'(offset), 7);
    end

    // Asynchronous reset pulse while locked clears everything at once
    @(negedge pixelClock);
    resetN = 1'b0;
    #1;
    checkAllZero("midLockReset");
    @(negedge pixelClock);
    resetN = 1'b1;
    repeat (2) @(posedge pixelClock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/tmds_symbol_aligner.md
# tmds_symbol_aligner

Receive-side counterpart to the HDMI/DVI transmit path. It takes unaligned 10-bit words from one TMDS channel's deserializer and finds the symbol boundary by locking onto control-token runs in blanking. It then decodes each aligned symbol into 8-bit video data or 2-bit control values. One instance is used per TMDS data channel, between the deserializer and the downstream video/data-island parser.

## Interface
- SEARCH_WINDOW, 4096: cycles spent at one bit offset before moving to the next. Must exceed one video line (1650 for 720p).
- TOKEN_RUN, 16: consecutive control tokens required to declare lock.
- LOCK_TIMEOUT, 8192: cycles without any control token, while locked, before lock is dropped.
- All three parameters lie in 2..65535. Internal counters are 16 bits and saturate.

Ports:
- pixelClock  in  1  TMDS character clock
- resetN  in  1  asynchronous active-low reset
- rawSymbol  in  10  deserializer word; bit 0 is the earliest received bit
- alignedSymbol  out  10  aligned 10-bit symbol, passed through for TERC4/guard-band parsing
- videoData  out  8  TMDS-decoded byte
- controlBits  out  2  {c1,c0} from the last control token
- isControl  out  1  alignedSymbol is one of the 4 control tokens
- locked  out  1  alignment lock held
- offset  out  4  current bit offset, 0..9

## Operation
- **Input pipeline**
  - Stage 0: r0 <= rawSymbol, r1 <= r0.
  - Stage 1: aligned <= {r0,r1}[offset +: 10].
  - Stage 2: decoded outputs are registered from aligned.
- **Control tokens**, written q[9:0]:
  - 1101010100 -> 00
  - 0010101011 -> 01
  - 0101010100 -> 10
  - 1010101011 -> 11
- **Video decode** is computed for every symbol:
  - t = q[9] ? ~q[7:0] : q[7:0].
  - d[0] = t[0].
  - For i = 1..7: d[i] = t[i]^t[i-1] if q[8]=1, else ~(t[i]^t[i-1]).
- **Control output rules**
  - controlBits updates only when isControl=1; otherwise it holds.
  - videoData updates every cycle.
- **State SEARCH** (locked=0)
  - run counts consecutive tokens seen in aligned.
  - timer counts cycles at the current offset.
  - run reaching TOKEN_RUN -> LOCKED.
  - Otherwise, timer reaching SEARCH_WINDOW-1 -> offset advances (9 wraps to 0), and run and timer clear.
- **State LOCKED** (locked=1)
  - offset is frozen.
  - gap counts cycles since the last control token and clears on any token.
  - gap reaching LOCK_TIMEOUT -> SEARCH. offset is kept, run, timer and gap clear, and the search resumes at the same offset.
- **Stale-symbol rule**: for the one cycle after an offset change, aligned still reflects the old offset. The token on that cycle does not increment run; run is held at 0.
- **Simultaneous events**
  - In SEARCH, a run completing in the same cycle as the timer expiring: lock wins, and offset does not advance.
  - In LOCKED, a token arriving in the same cycle gap would reach timeout: the token clears gap, and lock is held.

## Timing
- **Reset**: resetN low asynchronously clears all outputs to 0, sets state to SEARCH, sets offset to 0, and clears all counters. Deassertion is synchronised externally. Reset asserted mid-lock drops locked immediately.
- **Latency**: 3 pixelClock edges from the edge that samples the word holding a symbol's first bit to the registered outputs. This is the same for all offsets.
- **locked rise**: locked rises on the same edge that registers isControl=1 for the TOKEN_RUN-th consecutive token.
- **locked fall**: locked falls on the edge that registers gap = LOCK_TIMEOUT.
- **offset change**: offset changes on the edge where timer = SEARCH_WINDOW-1. The first symbol at the new offset appears at the outputs 2 edges later.
- There is no handshake. One symbol is processed per clock, and all outputs are valid every cycle after reset.

## Test plan
- **Reset**: hold resetN=0, drive random rawSymbol -> all outputs 0 and offset=0; release reset -> locked stays 0 until tokens arrive.
- **Aligned lock**: offset-0 stream of 20× 1101010100, TOKEN_RUN=16 -> isControl=1 from edge 3, locked=1 on edge 18, controlBits=00, offset=0.
- **Shifted lock**: stream shifted 7 bits, SEARCH_WINDOW=64, repeating 200 tokens 0101010100 + 100 video symbols -> offset steps 0..7 every 64 cycles, locks at 7, controlBits=10.
- **Decode**:
  - 0100000000 -> videoData=00, isControl=0.
  - 1000000000 -> videoData=FF.
  - 1010101011 -> isControl=1, controlBits=11.
- **Loss of lock**: after lock, LOCK_TIMEOUT=100, feed video only -> locked falls on the 100th cycle after the last token, offset retained. Restoring tokens relocks without an offset change.
- **Boundaries**:
  - Offset 9 with no tokens -> wraps to 0.
  - Token run completing on the timer-expiry cycle -> locks, no offset advance.
  - resetN pulse mid-lock -> immediate clear.
